// File: rtl/bitcnt_unit_pkg.sv
// Shared encodings and widths for the bit-count unit (state, op select, word/count widths).
package bitcnt_unit_pkg;

    localparam int WORD_W = 32;
    localparam int CNT_W  = 6;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    typedef enum logic {
        OP_POPCNT = 1'b0,
        OP_CLZ    = 1'b1
    } op_e;

endpackage

// File: rtl/bitcnt_unit_chunk_count.sv
// Combinational ones / leading-zero count over the low width_i bits of a chunk.
// The leading-zero path exists only when BITCNT_CLZ_EN is defined.
module chunk_count
    import bitcnt_unit_pkg::*;
(
    input  logic [WORD_W-1:0] chunk_i,
    input  logic [CNT_W-1:0]  width_i,
    output logic [CNT_W-1:0]  ones_o,
    output logic [CNT_W-1:0]  lz_o
);

    always_comb begin
        ones_o = '0;
        for (int i = 0; i < WORD_W; i++) begin
            if (i < int'(width_i)) begin
                ones_o = ones_o + CNT_W'(chunk_i[i]);
            end
        end
    end

`ifdef BITCNT_CLZ_EN
    logic seen;

    // Scan from the chunk's top valid bit downward until the first one.
    always_comb begin
        lz_o = '0;
        seen = 1'b0;
        for (int i = WORD_W - 1; i >= 0; i--) begin
            if (i < int'(width_i) && !seen) begin
                if (chunk_i[i]) begin
                    seen = 1'b1;
                end else begin
                    lz_o = lz_o + CNT_W'(1);
                end
            end
        end
    end
`else
    assign lz_o = '0;
`endif

endmodule

// File: rtl/bitcnt_unit.sv
// Multi-cycle popcount / count-leading-zeros unit, BYTES_PER_CYCLE bytes per RUN cycle.
// Define BITCNT_CLZ_EN to build the CLZ datapath; otherwise every operation is a popcount.
module bitcnt_unit
    import bitcnt_unit_pkg::*;
#(
    parameter int BYTES_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        op,
    input  logic [31:0] rs_data,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    localparam int         N        = 4 / BYTES_PER_CYCLE;
    localparam int         CHUNK_W  = 8 * BYTES_PER_CYCLE;
    localparam logic [1:0] LAST_IDX = 2'(N - 1);

    state_e             state_q;
    logic [WORD_W-1:0]  opnd_q;
    logic [CNT_W-1:0]   acc_q;
    logic [CNT_W-1:0]   acc_d;
    logic [1:0]         idx_q;
    logic               busy_q;
    logic               done_q;
    logic [CNT_W-1:0]   result_q;

    logic [1:0]         sel_idx;
    logic [4:0]         shamt;
    logic [WORD_W-1:0]  slice;
    logic [CNT_W-1:0]   ones;
    logic [CNT_W-1:0]   lz;

`ifdef BITCNT_CLZ_EN
    op_e                op_q;
    logic               frozen_q;
    logic               frozen_d;
`endif

    // Popcount walks chunks LSB-first, CLZ walks them MSB-first.
    always_comb begin
        sel_idx = idx_q;
`ifdef BITCNT_CLZ_EN
        if (op_q == OP_CLZ) begin
            sel_idx = LAST_IDX - idx_q;
        end
`endif
        shamt = 5'(int'(sel_idx) * CHUNK_W);
        slice = opnd_q >> shamt;
    end

    chunk_count u_chunk_count (
        .chunk_i (slice),
        .width_i (CNT_W'(CHUNK_W)),
        .ones_o  (ones),
        .lz_o    (lz)
    );

`ifdef BITCNT_CLZ_EN
    // CLZ stops accumulating after the first chunk that contains a one.
    always_comb begin
        acc_d    = acc_q;
        frozen_d = frozen_q;
        if (op_q == OP_CLZ) begin
            if (!frozen_q) begin
                acc_d = acc_q + lz;
            end
            if (ones != '0) begin
                frozen_d = 1'b1;
            end
        end else begin
            acc_d = acc_q + ones;
        end
    end
`else
    logic unused_clz;
    assign unused_clz = ^{op, lz};

    always_comb begin
        acc_d = acc_q + ones;
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            opnd_q   <= '0;
            acc_q    <= '0;
            idx_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
`ifdef BITCNT_CLZ_EN
            op_q     <= OP_POPCNT;
            frozen_q <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start && !flush) begin
                        opnd_q   <= rs_data;
                        acc_q    <= '0;
                        idx_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= RUN;
`ifdef BITCNT_CLZ_EN
                        op_q     <= op_e'(op);
                        frozen_q <= 1'b0;
`endif
                    end
                end
                RUN: begin
                    if (flush) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        acc_q <= acc_d;
                        idx_q <= idx_q + 2'd1;
`ifdef BITCNT_CLZ_EN
                        frozen_q <= frozen_d;
`endif
                        if (idx_q == LAST_IDX) begin
                            result_q <= acc_d;
                            done_q   <= 1'b1;
                            busy_q   <= 1'b0;
                            state_q  <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = {{(WORD_W - CNT_W){1'b0}}, result_q};

endmodule

// File: tb/tb_bitcnt_unit.sv
// Directed self-checking bench for bitcnt_unit with BYTES_PER_CYCLE=1 (four chunks per operation).
module tb_bitcnt_unit;

    localparam int N_CHUNKS = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        op;
    logic [31:0] rs_data;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    bitcnt_unit #(.BYTES_PER_CYCLE(1)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .rs_data (rs_data),
        .flush   (flush),
        .busy    (busy),
        .done    (done),
        .result  (result)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [31:0] d, input logic o);
        start   = 1'b1;
        rs_data = d;
        op      = o;
        tick();
        start   = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (done !== 1'b1 && cyc < 20) begin
            tick();
            cyc++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; op = 1'b0; flush = 1'b0; rs_data = '0;
        tick();
        tick();
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_state: busy=%b done=%b result=%0d, want 0/0/0", busy, done, result);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_popcount();
        logic [31:0] data [5] = '{32'hFFFF_FFFF, 32'h0000_0000, 32'h1234_5678, 32'h8000_0001, 32'h0000_00F0};
        logic [31:0] exp  [5] = '{32'd32, 32'd0, 32'd13, 32'd2, 32'd4};
        int cyc;
        for (int k = 0; k < 5; k++) begin
            launch(data[k], 1'b0);
            vectors++;
            if (busy !== 1'b1) begin
                miscompares++;
                $display("FAIL pop_busy_rise[%0d]: busy=%b, want 1", k, busy);
            end
            wait_done(cyc);
            vectors++;
            if (cyc !== N_CHUNKS || busy !== 1'b0) begin
                miscompares++;
                $display("FAIL pop_latency[%0d]: cycles=%0d busy=%b, want %0d/0", k, cyc, busy, N_CHUNKS);
            end
            vectors++;
            if (result !== exp[k]) begin
                miscompares++;
                $display("FAIL pop_result[%0d]: got %0d, want %0d", k, result, exp[k]);
            end
            tick();
            vectors++;
            if (done !== 1'b0 || result !== exp[k]) begin
                miscompares++;
                $display("FAIL pop_done_pulse[%0d]: done=%b result=%0d, want 0/%0d", k, done, result, exp[k]);
            end
        end
    endtask

    task automatic test_start_ignored();
        int cyc;
        launch(32'h0000_00FF, 1'b0);
        tick();
        start   = 1'b1;
        rs_data = 32'h0000_0000;
        tick();
        start   = 1'b0;
        wait_done(cyc);
        vectors++;
        if (cyc !== 2 || result !== 32'd8) begin
            miscompares++;
            $display("FAIL start_in_run: cycles=%0d result=%0d, want 2/8", cyc, result);
        end
        tick();
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL start_in_run_relaunch: busy=%b, want 0", busy);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        launch(32'h0000_00F0, 1'b0);
        wait_done(cyc);
        vectors++;
        if (result !== 32'd4) begin
            miscompares++;
            $display("FAIL b2b_first: got %0d, want 4", result);
        end
        start   = 1'b1;
        rs_data = 32'h0000_0003;
        tick();
        start   = 1'b0;
        vectors++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_accept: busy=%b done=%b, want 1/0", busy, done);
        end
        wait_done(cyc);
        vectors++;
        if (cyc !== N_CHUNKS || result !== 32'd2) begin
            miscompares++;
            $display("FAIL b2b_second: cycles=%0d result=%0d, want %0d/2", cyc, result, N_CHUNKS);
        end
        tick();
    endtask

    task automatic test_flush();
        int cyc;
        int pulses;
        launch(32'h0000_007F, 1'b0);
        wait_done(cyc);
        vectors++;
        if (result !== 32'd7) begin
            miscompares++;
            $display("FAIL flush_setup: got %0d, want 7", result);
        end
        tick();
        launch(32'h0000_FFFF, 1'b0);
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd7) begin
            miscompares++;
            $display("FAIL flush_abort: busy=%b done=%b result=%0d, want 0/0/7", busy, done, result);
        end
        pulses = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (done === 1'b1) pulses++;
        end
        vectors++;
        if (pulses !== 0 || result !== 32'd7) begin
            miscompares++;
            $display("FAIL flush_no_done: pulses=%0d result=%0d, want 0/7", pulses, result);
        end
        flush   = 1'b1;
        start   = 1'b1;
        rs_data = 32'hFFFF_FFFF;
        tick();
        flush   = 1'b0;
        start   = 1'b0;
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_beats_start: busy=%b, want 0", busy);
        end
        launch(32'h0000_0003, 1'b0);
        wait_done(cyc);
        vectors++;
        if (cyc !== N_CHUNKS || result !== 32'd2) begin
            miscompares++;
            $display("FAIL flush_next_start: cycles=%0d result=%0d, want %0d/2", cyc, result, N_CHUNKS);
        end
        tick();
    endtask

    task automatic test_reset_mid_run();
        int cyc;
        launch(32'hFFFF_FFFF, 1'b0);
        tick();
        tick();
        reset = 1'b1;
        #1;
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_mid_run: busy=%b done=%b result=%0d, want 0/0/0", busy, done, result);
        end
        #2;
        reset = 1'b0;
        launch(32'h0000_0001, 1'b0);
        wait_done(cyc);
        vectors++;
        if (cyc !== N_CHUNKS || result !== 32'd1) begin
            miscompares++;
            $display("FAIL reset_then_start: cycles=%0d result=%0d, want %0d/1", cyc, result, N_CHUNKS);
        end
        tick();
    endtask

`ifdef BITCNT_CLZ_EN
    task automatic test_clz();
        logic [31:0] data [5] = '{32'h0001_0000, 32'h0000_0000, 32'h8000_0000, 32'h0000_00FF, 32'h0000_0100};
        logic [31:0] exp  [5] = '{32'd15, 32'd32, 32'd0, 32'd24, 32'd23};
        int cyc;
        for (int k = 0; k < 5; k++) begin
            launch(data[k], 1'b1);
            wait_done(cyc);
            vectors++;
            if (cyc !== N_CHUNKS || result !== exp[k]) begin
                miscompares++;
                $display("FAIL clz[%0d]: cycles=%0d result=%0d, want %0d/%0d", k, cyc, result, N_CHUNKS, exp[k]);
            end
            tick();
        end
    endtask
`else
    task automatic test_op_ignored();
        logic [31:0] data [2] = '{32'h0000_000F, 32'h8000_0000};
        logic [31:0] exp  [2] = '{32'd4, 32'd1};
        int cyc;
        for (int k = 0; k < 2; k++) begin
            launch(data[k], 1'b1);
            wait_done(cyc);
            vectors++;
            if (cyc !== N_CHUNKS || result !== exp[k]) begin
                miscompares++;
                $display("FAIL op_ignored[%0d]: cycles=%0d result=%0d, want %0d/%0d", k, cyc, result, N_CHUNKS, exp[k]);
            end
            tick();
        end
    endtask
`endif

    initial begin
        test_reset();
        test_popcount();
        test_start_ignored();
        test_back_to_back();
        test_flush();
        test_reset_mid_run();
`ifdef BITCNT_CLZ_EN
        test_clz();
`else
        test_op_ignored();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
